imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
// PURPOSE
//  Shares the single read-only instruction memory between two requesters: the
//  fetch stage (port f_*) and the debug/program-loader port (d_*).
//  Arbitrates, drives the memory address, waits the fixed read latency,
//  captures the data and returns it to the winner with a one-cycle valid.
//  Filters misaligned and out-of-range addresses before they reach the memory.
// PARAMETERS
//  ADDR_W     64     address width (matches the instruction memory Address port)
//  DATA_W     32     instruction width
//  RD_CYCLES  2      cycles mem_addr is held before mem_data is sampled; legal >=1
//  MEM_BYTES  'h060  bytes populated; addresses >= MEM_BYTES are rejected
// PORTS
//  CLK       in   1       clock, rising edge
//  Reset_L   in   1       synchronous, active-low reset
//  f_req     in   1       fetch read request; held until f_gnt
//  f_addr    in   ADDR_W  fetch byte address
//  f_gnt     out  1       1-cycle pulse: fetch request accepted, f_addr captured
//  f_rvalid  out  1       1-cycle pulse: f_rdata/f_err valid
//  f_rdata   out  DATA_W  fetch read data
//  f_err     out  1       fetch access rejected (misaligned/out of range)
//  d_req     in   1       debug read request; held until d_gnt
//  d_addr    in   ADDR_W  debug byte address
//  d_gnt     out  1       1-cycle accept pulse for debug
//  d_rvalid  out  1       1-cycle pulse: d_rdata/d_err valid
//  d_rdata   out  DATA_W  debug read data
//  d_err     out  1       debug access rejected
//  mem_addr  out  ADDR_W  to instruction memory Address
//  mem_data  in   DATA_W  from instruction memory Data
//  busy      out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset (Reset_L=0 at a CLK edge): state IDLE; all gnt/rvalid/err=0, rdata=0,
//    mem_addr=0, busy=0, rr pointer = fetch-priority. Aborts any access in
//    flight; no rvalid is ever produced for an aborted access.
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE; error path IDLE -> RESP -> IDLE.
//  - IDLE: if any req, grant one (gnt combinational, same cycle, registered
//    capture of addr and owner). Only one gnt per cycle, never both.
//  - Arbitration: round-robin. Both requesting: owner = port not granted last;
//    after reset fetch wins first. Single requester always wins.
//  - Check at grant: addr[1:0]!=0 or addr>=MEM_BYTES -> error; go straight to
//    RESP, mem_addr unchanged, rdata=0, err=1.
//  - ACCESS: mem_addr = captured addr, held stable for RD_CYCLES cycles
//    (down-counter, width clog2(RD_CYCLES+1)); mem_data sampled at the edge
//    ending the last ACCESS cycle.
//  - RESP: owner rvalid=1 for exactly one cycle with registered rdata/err;
//    other port rvalid=0. rdata/err hold value until next RESP for that port.
//  - Latency: gnt at cycle T -> rvalid at T+RD_CYCLES+1 (error: T+1).
//    Max throughput one access per RD_CYCLES+2 cycles. No grant in ACCESS/RESP.
//  - mem_addr only changes on entry to ACCESS (no spurious memory activity).
//  - Req dropped before gnt: no access. Req changed after gnt: ignored.
//  - mem_data X (unmapped word) is passed through unchanged; not masked.
// TESTING
//  1 Fetch 0x000, RD_CYCLES=2: f_gnt at T -> f_rvalid at T+3, f_rdata=F84003E9,
//    f_err=0, d_rvalid never high.
//  2 After reset f_req(0x004)+d_req(0x008) held: fetch first (F84083EA), then
//    debug (F84103EB), then fetch again; gnts never overlap.
//  3 f_addr=0x002: f_gnt at T, f_rvalid+f_err at T+1, f_rdata=0, mem_addr unchanged.
//  4 d_addr=0x060 (MEM_BYTES='h060): d_err=1 at T+1; d_addr=0x05C: no error.
//  5 Reset_L=0 during ACCESS: next cycle all outputs at reset values, no rvalid;
//    after release, f_req(0x014) returns AA0B014A normally.
//  6 f_req held high, addr stepping 0x000..0x02C by 4 on each f_gnt: responses
//    every 4 cycles, data matches program words in order.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares one read-only instruction memory between the
// fetch port (f_*) and the debug/loader port (d_*). It arbitrates round-robin,
// rejects misaligned or out-of-range addresses, holds mem_addr for RD_CYCLES,
// and returns the captured word to the winner with a one-cycle rvalid.
module imem_access_arbiter #(
  parameter int unsigned             ADDR_W    = 64,
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             RD_CYCLES = 2,
  parameter logic [ADDR_W-1:0]       MEM_BYTES = 'h060
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(RD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state_q;
  logic                owner_q;     // 1: debug owns the access in flight
  logic                last_d_q;    // 1: debug was granted most recently
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                f_rvalid_q;
  logic [DATA_W-1:0]   f_rdata_q;
  logic                f_err_q;
  logic                d_rvalid_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                d_err_q;

  logic                grant_f;
  logic                grant_d;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_bad;

  // Same-cycle grant in IDLE; suppressed while in reset so no requester sees
  // a grant whose capture the reset edge would discard.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (Reset_L && (state_q == S_IDLE)) begin
      if (f_req && d_req) begin
        grant_f = last_d_q;
        grant_d = !last_d_q;
      end else begin
        grant_f = f_req;
        grant_d = d_req;
      end
    end
  end

  // Address of the winner and its legality check.
  always_comb begin
    sel_addr = grant_d ? d_addr : f_addr;
    sel_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr >= MEM_BYTES);
  end

  // Arbitration FSM with registered memory address and response outputs.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_d_q   <= 1'b1;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      f_err_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_f || grant_d) begin
            owner_q  <= grant_d;
            last_d_q <= grant_d;
            if (sel_bad) begin
              // Rejected access skips the memory entirely; mem_addr untouched.
              state_q <= S_RESP;
              if (grant_d) begin
                d_rvalid_q <= 1'b1;
                d_rdata_q  <= '0;
                d_err_q    <= 1'b1;
              end else begin
                f_rvalid_q <= 1'b1;
                f_rdata_q  <= '0;
                f_err_q    <= 1'b1;
              end
            end else begin
              state_q    <= S_ACCESS;
              mem_addr_q <= sel_addr;
              cnt_q      <= CNT_W'(RD_CYCLES);
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_RESP;
            if (owner_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_data;
              d_err_q    <= 1'b0;
            end else begin
              f_rvalid_q <= 1'b1;
              f_rdata_q  <= mem_data;
              f_err_q    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign f_gnt    = grant_f;
  assign d_gnt    = grant_d;
  assign f_rvalid = f_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign f_err    = f_err_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a small program-memory model.
module tb_imem_access_arbiter;

  localparam int unsigned RDC = 2;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic        f_gnt, f_rvalid, f_err;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0;
  logic [63:0] d_addr = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [63:0] mem_addr;
  logic [31:0] mem_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] prog [0:23];

  imem_access_arbiter #(
    .ADDR_W   (64),
    .DATA_W   (32),
    .RD_CYCLES(RDC),
    .MEM_BYTES(64'h060)
  ) dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata (f_rdata),
    .f_err   (f_err),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .busy    (busy)
  );

  always #5 CLK = ~CLK;

  // Asynchronous-read program memory; unmapped words read as X.
  always_comb begin
    mem_data = 'x;
    if (mem_addr < 64'h060) mem_data = prog[mem_addr[6:2]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    Reset_L = 1'b0;
    f_req = 1'b0;
    d_req = 1'b0;
    cyc();
    cyc();
    Reset_L = 1'b1;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_f_gnt"}, f_gnt, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_f_rvalid"}, f_rvalid, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_f_err"}, f_err, 0);
    chk({tag, "_d_err"}, d_err, 0);
    chk({tag, "_f_rdata"}, f_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One isolated read: grant, exact-latency response, then back to idle.
  task automatic do_read(input bit dbg, input logic [63:0] addr,
                         input logic [31:0] exp_data, input bit exp_err,
                         input string tag);
    logic [63:0] ma0;
    int unsigned lat;
    lat = exp_err ? 1 : RDC + 1;
    cyc();
    ma0 = mem_addr;
    if (dbg) begin d_req = 1'b1; d_addr = addr; end
    else     begin f_req = 1'b1; f_addr = addr; end
    #1;
    chk({tag, "_gnt"}, dbg ? d_gnt : f_gnt, 1);
    chk({tag, "_gnt_other"}, dbg ? f_gnt : d_gnt, 0);
    for (int unsigned i = 1; i <= lat; i++) begin
      cyc();
      f_req = 1'b0;
      d_req = 1'b0;
      #1;
      if (i == 1) chk({tag, "_mem_addr"}, mem_addr, exp_err ? ma0 : addr);
      if (i < lat) begin
        chk({tag, "_early_rvalid"}, dbg ? d_rvalid : f_rvalid, 0);
      end else begin
        chk({tag, "_rvalid"}, dbg ? d_rvalid : f_rvalid, 1);
        chk({tag, "_rdata"}, dbg ? d_rdata : f_rdata, exp_data);
        chk({tag, "_err"}, dbg ? d_err : f_err, exp_err);
        chk({tag, "_other_rvalid"}, dbg ? f_rvalid : d_rvalid, 0);
      end
    end
    cyc();
    #1;
    chk({tag, "_rvalid_drop"}, dbg ? d_rvalid : f_rvalid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin : stim
    bit exp_fg [0:11];
    bit exp_dg [0:11];
    bit exp_fv [0:11];
    bit exp_dv [0:11];
    int idx, ridx, lastc;

    for (int i = 0; i < 24; i++) prog[i] = 32'h8B000000 + 32'(i);
    prog[0] = 32'hF84003E9;
    prog[1] = 32'hF84083EA;
    prog[2] = 32'hF84103EB;
    prog[5] = 32'hAA0B014A;

    // Reset state
    do_reset();
    chk_reset_vals("rst");

    // Basic fetch with RD_CYCLES latency
    do_read(0, 64'h000, 32'hF84003E9, 0, "fetch0");

    // Round-robin with both requesters held after reset
    do_reset();
    for (int c = 0; c < 12; c++) begin
      exp_fg[c] = (c == 0) || (c == 8);
      exp_dg[c] = (c == 4);
      exp_fv[c] = (c == 3) || (c == 11);
      exp_dv[c] = (c == 7);
    end
    for (int c = 0; c < 12; c++) begin
      cyc();
      f_req  = (c <= 8);
      f_addr = 64'h004;
      d_req  = (c <= 4);
      d_addr = 64'h008;
      #1;
      chk($sformatf("rr_fgnt_c%0d", c), f_gnt, exp_fg[c]);
      chk($sformatf("rr_dgnt_c%0d", c), d_gnt, exp_dg[c]);
      chk($sformatf("rr_fvalid_c%0d", c), f_rvalid, exp_fv[c]);
      chk($sformatf("rr_dvalid_c%0d", c), d_rvalid, exp_dv[c]);
      if (exp_fv[c]) chk($sformatf("rr_fdata_c%0d", c), f_rdata, 32'hF84083EA);
      if (exp_dv[c]) chk($sformatf("rr_ddata_c%0d", c), d_rdata, 32'hF84103EB);
    end
    f_req = 1'b0;
    d_req = 1'b0;
    cyc();
    cyc();

    // Error paths: misaligned, out of range, and last legal word
    do_read(0, 64'h002, 32'h0, 1, "misalign");
    do_read(1, 64'h060, 32'h0, 1, "range_hi");
    do_read(1, 64'h05C, prog[23], 0, "range_last");

    // Reset in the middle of an access
    cyc();
    f_req = 1'b1;
    f_addr = 64'h010;
    #1;
    chk("abort_gnt", f_gnt, 1);
    cyc();
    f_req = 1'b0;
    Reset_L = 1'b0;
    #1;
    chk("abort_in_access", busy, 1);
    cyc();
    Reset_L = 1'b1;
    #1;
    chk_reset_vals("abort");
    for (int c = 0; c < 4; c++) begin
      cyc();
      #1;
      chk($sformatf("abort_no_rvalid_c%0d", c), f_rvalid, 0);
    end
    do_read(0, 64'h014, 32'hAA0B014A, 0, "after_abort");

    // Back-to-back fetch stream at full throughput
    idx = 0;
    ridx = 0;
    lastc = 0;
    for (int c = 0; c < 80 && ridx < 12; c++) begin
      cyc();
      f_req  = (idx < 12);
      f_addr = 64'(4 * idx);
      #1;
      if (f_gnt) idx++;
      if (f_rvalid) begin
        chk($sformatf("stream_data_%0d", ridx), f_rdata, prog[ridx]);
        if (ridx > 0) chk($sformatf("stream_gap_%0d", ridx), 64'(c - lastc), 4);
        lastc = c;
        ridx++;
      end
    end
    f_req = 1'b0;
    chk("stream_count", 64'(ridx), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
